// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, one-entry skid buffer,
// flush and interrupt conversion. Define IF_ID_PERF_EN to add stall/flush perf counters.
module if_id_skid_reg #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = PC_W'(32'h8000_0000),
  parameter logic [DATA_W-1:0]    NOP_INST = '0,
  parameter logic [PC_W-1:0]      IRQ_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              irq,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_irq,
  output logic              skid_full
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t              state, state_n;
  logic [DATA_W-1:0] out_inst_n, skid_inst, skid_inst_n;
  logic [PC_W-1:0]   out_pc_n, skid_pc, skid_pc_n;
  logic              out_irq_n;
  logic              accept, load;
  logic              src_valid;
  logic [DATA_W-1:0] src_inst;
  logic [PC_W-1:0]   src_pc;

  assign out_valid = (state != EMPTY);
  assign skid_full = (state == TWO);
  assign in_ready  = ~skid_full;
  assign accept    = in_valid & in_ready;
  assign load      = ~stall | ~out_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      out_inst  <= NOP_INST;
      out_pc    <= RESET_PC;
      out_irq   <= 1'b0;
      skid_inst <= '0;
      skid_pc   <= '0;
    end else begin
      state     <= state_n;
      out_inst  <= out_inst_n;
      out_pc    <= out_pc_n;
      out_irq   <= out_irq_n;
      skid_inst <= skid_inst_n;
      skid_pc   <= skid_pc_n;
    end
  end

  always_comb begin
    state_n     = state;
    out_inst_n  = out_inst;
    out_pc_n    = out_pc;
    out_irq_n   = out_irq;
    skid_inst_n = skid_inst;
    skid_pc_n   = skid_pc;
    src_valid   = 1'b0;
    src_inst    = in_inst;
    src_pc      = in_pc;

    if (flush) begin
      state_n    = EMPTY;
      out_inst_n = NOP_INST;
      out_pc_n   = in_pc;
      out_irq_n  = 1'b0;
    end else if (load) begin
      // Skid entry is always older than the current input, so it drains first.
      if (state == TWO) begin
        src_valid = 1'b1;
        src_inst  = skid_inst;
        src_pc    = skid_pc;
      end else if (accept) begin
        src_valid = 1'b1;
      end

      if (src_valid) begin
        state_n = ONE;
        if (irq) begin
          out_inst_n = NOP_INST;
          out_pc_n   = IRQ_PC;
          out_irq_n  = 1'b1;
        end else begin
          out_inst_n = src_inst;
          out_pc_n   = src_pc;
          out_irq_n  = 1'b0;
        end
      end else begin
        state_n    = EMPTY;
        out_inst_n = NOP_INST;
        out_irq_n  = 1'b0;
      end
    end else if (accept) begin
      state_n     = TWO;
      skid_inst_n = in_inst;
      skid_pc_n   = in_pc;
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && out_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
